m_cp0: RTL and testbench

M_CP0 -- requirements
Module: m_cp0

---
 rtl/m_cp0.sv | 116 +++++++++++
 tb/tb_m_cp0.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/m_cp0.sv
// CP0 subset: SR/Cause/EPC, exception and interrupt request generation; optional PRId read under CP0_PRID_EN.
// Latency: dout/epcOut/req are combinational, state updates on the next clk edge; no backpressure.
// Reset: reset=0 asynchronously clears all state. A request (req=1) blocks the mtc0 write and eret in that cycle.
module m_cp0 #(
    parameter logic [31:0] PRID_VALUE = 32'h2023_0007
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        we,
    input  logic [4:0]  addr,
    input  logic [31:0] din,
    output logic [31:0] dout,
    input  logic [31:0] vPC,
    input  logic        bdIn,
    input  logic [4:0]  excCodeIn,
    input  logic [5:0]  hwInt,
    input  logic        eret,
    output logic [31:0] epcOut,
    output logic        req
);

    logic [5:0]  im_q, im_d;
    logic        exl_q, exl_d;
    logic        ie_q, ie_d;
    logic        bd_q, bd_d;
    logic [5:0]  ip_q;
    logic [4:0]  exc_q, exc_d;
    logic [31:0] epc_q, epc_d;

    logic        int_req;
    logic        exc_req;
    logic [31:0] sr_val;
    logic [31:0] cause_val;

    assign int_req   = (|(hwInt & im_q)) & ie_q & ~exl_q;
    assign exc_req   = (excCodeIn != 5'd0) & ~exl_q;
    assign req       = int_req | exc_req;
    assign epcOut    = epc_q;
    assign sr_val    = {16'd0, im_q, 8'd0, exl_q, ie_q};
    assign cause_val = {bd_q, 15'd0, ip_q, 3'd0, exc_q, 2'd0};

    always_comb begin
        im_d  = im_q;
        exl_d = exl_q;
        ie_d  = ie_q;
        bd_d  = bd_q;
        exc_d = exc_q;
        epc_d = epc_q;
        if (req) begin
            // Interrupts outrank synchronous exceptions: ExcCode 0 whenever int_req is set.
            exl_d = 1'b1;
            bd_d  = bdIn;
            epc_d = bdIn ? (vPC - 32'd4) : vPC;
            exc_d = int_req ? 5'd0 : excCodeIn;
        end else begin
            if (we && (addr == 5'd12)) begin
                im_d  = din[15:10];
                exl_d = din[1];
                ie_d  = din[0];
            end
            if (we && (addr == 5'd14)) begin
                epc_d = din;
            end
            if (eret) begin
                exl_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            im_q  <= 6'd0;
            exl_q <= 1'b0;
            ie_q  <= 1'b0;
            bd_q  <= 1'b0;
            ip_q  <= 6'd0;
            exc_q <= 5'd0;
            epc_q <= 32'd0;
        end else begin
            im_q  <= im_d;
            exl_q <= exl_d;
            ie_q  <= ie_d;
            bd_q  <= bd_d;
            ip_q  <= hwInt;
            exc_q <= exc_d;
            epc_q <= epc_d;
        end
    end

`ifdef CP0_PRID_EN
    always_comb begin
        dout = 32'd0;
        case (addr)
            5'd12:   dout = sr_val;
            5'd13:   dout = cause_val;
            5'd14:   dout = epc_q;
            5'd15:   dout = PRID_VALUE;
            default: dout = 32'd0;
        endcase
    end
`else
    logic unused_prid;
    assign unused_prid = ^PRID_VALUE;

    always_comb begin
        dout = 32'd0;
        case (addr)
            5'd12:   dout = sr_val;
            5'd13:   dout = cause_val;
            5'd14:   dout = epc_q;
            default: dout = 32'd0;
        endcase
    end
`endif

endmodule

// File: tb/tb_m_cp0.sv
// Bench for m_cp0: register-level reference model, expected outputs queued per cycle and checked by a negedge monitor.
module tb_m_cp0;

    localparam logic [31:0] PRID = 32'h2023_0007;

    logic        clk = 1'b0;
    logic        reset;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] din;
    logic [31:0] dout;
    logic [31:0] vPC;
    logic        bdIn;
    logic [4:0]  excCodeIn;
    logic [5:0]  hwInt;
    logic        eret;
    logic [31:0] epcOut;
    logic        req;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] dout;
        logic [31:0] epc;
        logic        req;
    } exp_t;

    exp_t exp_q[$];

    // Architectural register words as software sees them.
    logic [31:0] m_sr, m_cause, m_epc;

    m_cp0 #(.PRID_VALUE(PRID)) dut (
        .clk(clk), .reset(reset), .we(we), .addr(addr), .din(din), .dout(dout),
        .vPC(vPC), .bdIn(bdIn), .excCodeIn(excCodeIn), .hwInt(hwInt), .eret(eret),
        .epcOut(epcOut), .req(req)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
        end
    endtask

    function automatic logic model_int();
        return ((hwInt & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
    endfunction

    function automatic logic model_req();
        return model_int() || ((excCodeIn != 5'd0) && !m_sr[1]);
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] a);
        if (a == 5'd12) return m_sr;
        if (a == 5'd13) return m_cause;
        if (a == 5'd14) return m_epc;
`ifdef CP0_PRID_EN
        if (a == 5'd15) return PRID;
`endif
        return 32'd0;
    endfunction

    task automatic model_reset();
        m_sr = 32'd0; m_cause = 32'd0; m_epc = 32'd0;
    endtask

    task automatic model_step();
        logic irq, r;
        irq = model_int();
        r   = model_req();
        if (r) begin
            m_sr[1]       = 1'b1;
            m_cause[31]   = bdIn;
            m_cause[6:2]  = irq ? 5'd0 : excCodeIn;
            m_epc         = bdIn ? vPC - 32'd4 : vPC;
        end else begin
            if (we && addr == 5'd12) m_sr = din & 32'h0000_FC03;
            if (we && addr == 5'd14) m_epc = din;
            if (eret) m_sr[1] = 1'b0;
        end
        m_cause[15:10] = hwInt;
    endtask

    task automatic drive(input logic w, input logic [4:0] a, input logic [31:0] d, input logic [31:0] pc,
                         input logic bd, input logic [4:0] ec, input logic [5:0] hw, input logic er);
        we = w; addr = a; din = d; vPC = pc; bdIn = bd; excCodeIn = ec; hwInt = hw; eret = er;
    endtask

    task automatic apply(input logic w, input logic [4:0] a, input logic [31:0] d, input logic [31:0] pc,
                         input logic bd, input logic [4:0] ec, input logic [5:0] hw, input logic er);
        exp_t e;
        @(posedge clk);
        model_step();
        #1;
        drive(w, a, d, pc, bd, ec, hw, er);
        e.dout = model_read(a);
        e.epc  = m_epc;
        e.req  = model_req();
        exp_q.push_back(e);
        #1;
    endtask

    task automatic idle(input logic [4:0] a, input logic [5:0] hw);
        apply(1'b0, a, 32'd0, 32'h0000_0100, 1'b0, 5'd0, hw, 1'b0);
    endtask

    task automatic rand_cycle();
        logic [4:0]  a, ec;
        logic [5:0]  hw;
        int          sel;
        logic [4:0]  codes[8];
        codes = '{5'd0, 5'd0, 5'd0, 5'd4, 5'd5, 5'd8, 5'd10, 5'd12};
        sel = $urandom_range(0, 5);
        a   = (sel < 4) ? 5'(12 + sel) : 5'($urandom_range(0, 31));
        ec  = ($urandom_range(0, 3) == 0) ? codes[$urandom_range(0, 7)] : 5'd0;
        hw  = ($urandom_range(0, 2) == 0) ? 6'($urandom) : 6'd0;
        apply($urandom_range(0, 2) == 0, a, $urandom, {$urandom} & 32'hFFFF_FFFC,
              1'($urandom), ec, hw, $urandom_range(0, 5) == 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("dout", dout, e.dout);
                check("epcOut", epcOut, e.epc);
                check("req", {31'd0, req}, {31'd0, e.req});
            end
        end
    end

    initial begin : stim
        reset = 1'b0;
        drive(1'b0, 5'd12, 32'd0, 32'd0, 1'b0, 5'd0, 6'd0, 1'b0);
        model_reset();
        #2;
        check("rst_dout", dout, 32'd0);
        check("rst_epc", epcOut, 32'd0);
        check("rst_req", {31'd0, req}, 32'd0);
        #10 reset = 1'b1;

        // Overflow exception
        apply(1'b1, 5'd12, 32'h0000_0001, 32'h0, 1'b0, 5'd0, 6'd0, 1'b0);
        apply(1'b0, 5'd13, 32'h0, 32'h0000_3010, 1'b0, 5'd12, 6'd0, 1'b0);
        check("ov_req", {31'd0, req}, 32'd1);
        idle(5'd13, 6'd0);
        check("ov_cause", dout, 32'h0000_0030);
        check("ov_epc", epcOut, 32'h0000_3010);
        idle(5'd12, 6'd0);
        check("ov_sr", dout, 32'h0000_0003);

        // EXL masks a new exception
        apply(1'b0, 5'd12, 32'h0, 32'h0000_0200, 1'b0, 5'd10, 6'd0, 1'b0);
        check("exl_mask_req", {31'd0, req}, 32'd0);
        idle(5'd12, 6'd0);
        check("exl_mask_sr", dout, 32'h0000_0003);

        // eret clears EXL, EPC stays
        apply(1'b0, 5'd12, 32'h0, 32'h0, 1'b0, 5'd0, 6'd0, 1'b1);
        idle(5'd12, 6'd0);
        check("eret_sr", dout, 32'h0000_0001);
        check("eret_epc", epcOut, 32'h0000_3010);

        // Interrupt in a delay slot
        apply(1'b1, 5'd12, 32'h0000_0401, 32'h0, 1'b0, 5'd0, 6'd0, 1'b0);
        apply(1'b0, 5'd13, 32'h0, 32'h0000_3024, 1'b1, 5'd0, 6'b000001, 1'b0);
        check("ds_req", {31'd0, req}, 32'd1);
        idle(5'd13, 6'b000001);
        check("ds_cause", dout, 32'h8000_0400);
        check("ds_epc", epcOut, 32'h0000_3020);

        // Request beats a same-cycle mtc0; Cause writes ignored
        apply(1'b1, 5'd12, 32'h0000_0001, 32'h0, 1'b0, 5'd0, 6'd0, 1'b0);
        apply(1'b1, 5'd14, 32'h0000_5000, 32'h0000_4000, 1'b0, 5'd8, 6'd0, 1'b0);
        check("wr_vs_req", {31'd0, req}, 32'd1);
        apply(1'b1, 5'd13, 32'hFFFF_FFFF, 32'h0, 1'b0, 5'd0, 6'd0, 1'b0);
        check("wr_vs_req_epc", epcOut, 32'h0000_4000);
        idle(5'd13, 6'd0);
        check("cause_wr_ignored", dout, 32'h0000_0020);

        // IE=0 masks all interrupt lines; eret together with an SR write that sets EXL
        apply(1'b1, 5'd12, 32'h0000_FC02, 32'h0, 1'b0, 5'd0, 6'd0, 1'b1);
        apply(1'b0, 5'd12, 32'h0, 32'h0, 1'b0, 5'd0, 6'h3F, 1'b0);
        check("ie_mask_req", {31'd0, req}, 32'd0);
        check("eret_wins_sr", dout, 32'h0000_FC00);

        for (int i = 0; i < 400; i++) rand_cycle();

        // Reset pulled between edges
        @(negedge clk);
        #1;
        reset = 1'b0;
        drive(1'b0, 5'd15, 32'd0, 32'd0, 1'b0, 5'd0, 6'd0, 1'b0);
        model_reset();
        #1;
        check("mid_rst_epc", epcOut, 32'd0);
        check("mid_rst_req", {31'd0, req}, 32'd0);
        check("mid_rst_prid", dout, model_read(5'd15));
        addr = 5'd14;
        #1;
        check("mid_rst_dout", dout, 32'd0);
        reset = 1'b1;

        for (int i = 0; i < 200; i++) rand_cycle();
        idle(5'd12, 6'd0);
        repeat (3) @(posedge clk);
        check("queue_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
